// File: rtl/actuator_pkg.sv
// Shared constants and helpers for the servo/ESC pulse generator.
package actuator_pkg;

  // Default timing at a 100 MHz clock.
  localparam int unsigned PERIOD_CYCLES_DEF = 2_000_000;
  localparam int unsigned MIN_PW_DEF        = 100_000;
  localparam int unsigned MAX_PW_DEF        = 200_000;
  localparam int unsigned NEUTRAL_PW_DEF    = 150_000;

  // Bit positions inside the control register.
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_NEUTRAL = 1;

  // Limit a requested pulse width to [mn, mx] on the full 32-bit value.
  function automatic logic [31:0] clamp_pw(input logic [31:0] x,
                                           input logic [31:0] mn,
                                           input logic [31:0] mx);
    logic [31:0] r;
    if (x < mn) begin
      r = mn;
    end else if (x > mx) begin
      r = mx;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/actuator_pwm_chan.sv
// One PWM channel: shadow width register, clamp/neutral select and the
// registered comparator. Works on the next-cycle counter so the output
// flop lines up with the frame counter.
module actuator_pwm_chan
  import actuator_pkg::*;
#(
  parameter int unsigned CNT_W      = 21,
  parameter int unsigned MIN_PW     = MIN_PW_DEF,
  parameter int unsigned MAX_PW     = MAX_PW_DEF,
  parameter int unsigned NEUTRAL_PW = NEUTRAL_PW_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] cnt_i,       // counter value for the coming cycle
  input  logic             load_i,      // shadow load on this edge
  input  logic             neutral_i,   // load neutral instead of the request
  input  logic             en_i,        // enable for the coming cycle
  input  logic [31:0]      reg_width_i,
  output logic             pwm_o
);

  localparam logic [CNT_W-1:0] NEUT_W = CNT_W'(NEUTRAL_PW);

  logic [CNT_W-1:0] width_q, width_d;
  logic             pwm_q, pwm_d;
  logic [31:0]      clamped_s;

  // Select the new shadow width and the next pulse level.
  always_comb begin
    clamped_s = clamp_pw(reg_width_i, 32'(MIN_PW), 32'(MAX_PW));
    width_d   = width_q;
    if (load_i) begin
      if (neutral_i) begin
        width_d = NEUT_W;
      end else begin
        width_d = clamped_s[CNT_W-1:0];
      end
    end else begin
      width_d = width_q;
    end
    pwm_d = en_i && (cnt_i < width_d);
  end

  // Shadow width and output flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      width_q <= NEUT_W;
      pwm_q   <= 1'b0;
    end else begin
      width_q <= width_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/actuator_pwm_gen.sv
// Frame-synchronous steering servo / throttle ESC pulse generator with
// double-buffered registers and a frame watchdog that forces neutral.
module actuator_pwm_gen
  import actuator_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = PERIOD_CYCLES_DEF,
  parameter int unsigned CNT_W         = 21,
  parameter int unsigned MIN_PW        = MIN_PW_DEF,
  parameter int unsigned MAX_PW        = MAX_PW_DEF,
  parameter int unsigned NEUTRAL_PW    = NEUTRAL_PW_DEF,
  parameter int unsigned WDOG_FRAMES   = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] reg_steer,
  input  logic [31:0] reg_throttle,
  input  logic [31:0] reg_ctrl,
  input  logic        reg_wr_strobe,
  output logic        pwm_steer,
  output logic        pwm_throttle,
  output logic        frame_start,
  output logic        wdog_tripped
);

  localparam int unsigned      WD_W   = $clog2(WDOG_FRAMES + 1);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_MAX = WD_W'(WDOG_FRAMES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;   // low for the first edge out of reset
  logic             en_q, en_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             trip_q, trip_d;
  logic             fs_q, fs_d;
  logic             wrap_s;
  logic             neutral_s;
  logic             ctrl_unused_s;

  assign ctrl_unused_s = ^reg_ctrl[31:2];

  // Frame counter, control shadow and watchdog next-state.
  always_comb begin
    wrap_s   = run_q && (cnt_q == LAST);
    run_d    = 1'b1;
    cnt_d    = cnt_q + CNT_W'(1);
    en_d     = en_q;
    wd_cnt_d = wd_cnt_q;
    trip_d   = trip_q;
    // Counter holds at 0 across the first edge so frame 0 is a full frame.
    if (!run_q || wrap_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (wrap_s) begin
      en_d = reg_ctrl[CTRL_EN];
    end else begin
      en_d = en_q;
    end
    // A write always wins over a coincident wrap.
    if (reg_wr_strobe) begin
      wd_cnt_d = '0;
      trip_d   = 1'b0;
    end else if (wrap_s) begin
      if (wd_cnt_q < WD_MAX) begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end else begin
        wd_cnt_d = wd_cnt_q;
      end
      trip_d = trip_q | (wd_cnt_d == WD_MAX);
    end else begin
      wd_cnt_d = wd_cnt_q;
      trip_d   = trip_q;
    end
    // A trip on the load edge applies neutral in that same load.
    neutral_s = reg_ctrl[CTRL_NEUTRAL] | trip_d;
    fs_d      = (cnt_d == '0);
  end

  // Counter, control shadow, watchdog and frame_start flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      run_q    <= 1'b0;
      en_q     <= 1'b0;
      wd_cnt_q <= '0;
      trip_q   <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      en_q     <= en_d;
      wd_cnt_q <= wd_cnt_d;
      trip_q   <= trip_d;
      fs_q     <= fs_d;
    end
  end

  actuator_pwm_chan #(
    .CNT_W(CNT_W), .MIN_PW(MIN_PW), .MAX_PW(MAX_PW), .NEUTRAL_PW(NEUTRAL_PW)
  ) u_steer (
    .clk_i(clock), .rst_i(reset), .cnt_i(cnt_d), .load_i(wrap_s),
    .neutral_i(neutral_s), .en_i(en_d), .reg_width_i(reg_steer),
    .pwm_o(pwm_steer)
  );

  actuator_pwm_chan #(
    .CNT_W(CNT_W), .MIN_PW(MIN_PW), .MAX_PW(MAX_PW), .NEUTRAL_PW(NEUTRAL_PW)
  ) u_throttle (
    .clk_i(clock), .rst_i(reset), .cnt_i(cnt_d), .load_i(wrap_s),
    .neutral_i(neutral_s), .en_i(en_d), .reg_width_i(reg_throttle),
    .pwm_o(pwm_throttle)
  );

  assign frame_start  = fs_q;
  assign wdog_tripped = trip_q;

endmodule

// File: tb/tb_actuator_pwm_gen.sv
// Bench for actuator_pwm_gen: frame-level reference model checked every
// cycle, directed pulse-width measurements and a randomized phase.
module tb_actuator_pwm_gen;

  localparam int P    = 100;
  localparam int MINW = 5;
  localparam int MAXW = 20;
  localparam int NEUW = 12;
  localparam int WDF  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] reg_steer = 32'd0;
  logic [31:0] reg_throttle = 32'd0;
  logic [31:0] reg_ctrl = 32'd0;
  logic        reg_wr_strobe = 1'b0;
  logic        pwm_steer, pwm_throttle, frame_start, wdog_tripped;

  int checks = 0;
  int failures = 0;

  actuator_pwm_gen #(
    .PERIOD_CYCLES(P), .CNT_W(7), .MIN_PW(MINW), .MAX_PW(MAXW),
    .NEUTRAL_PW(NEUW), .WDOG_FRAMES(WDF)
  ) dut (
    .clock(clock), .reset(reset), .reg_steer(reg_steer),
    .reg_throttle(reg_throttle), .reg_ctrl(reg_ctrl),
    .reg_wr_strobe(reg_wr_strobe), .pwm_steer(pwm_steer),
    .pwm_throttle(pwm_throttle), .frame_start(frame_start),
    .wdog_tripped(wdog_tripped)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampw(input logic [31:0] x);
    if (x < 32'(MINW)) return MINW;
    if (x > 32'(MAXW)) return MAXW;
    return int'(x);
  endfunction

  // Reference model: position inside the frame plus the per-frame settings.
  int pos = -1;     // -1: in reset, nothing running yet
  int m_ws = NEUW, m_wt = NEUW, m_wd = 0;
  bit m_en = 1'b0, m_trip = 1'b0;
  bit exp_fs = 1'b0, exp_ps = 1'b0, exp_pt = 1'b0;

  always @(posedge clock) begin
    bit at_wrap;
    if (reset) begin
      pos = -1; m_en = 1'b0; m_ws = NEUW; m_wt = NEUW; m_wd = 0; m_trip = 1'b0;
    end else begin
      at_wrap = (pos == P - 1);
      if (reg_wr_strobe) begin
        m_wd = 0; m_trip = 1'b0;
      end else if (at_wrap) begin
        if (m_wd < WDF) m_wd++;
        if (m_wd == WDF) m_trip = 1'b1;
      end
      pos = (pos < 0) ? 0 : (pos + 1) % P;
      if (at_wrap) begin
        m_en = reg_ctrl[0];
        if (reg_ctrl[1] || m_trip) begin
          m_ws = NEUW; m_wt = NEUW;
        end else begin
          m_ws = clampw(reg_steer); m_wt = clampw(reg_throttle);
        end
      end
    end
    exp_fs = (pos == 0);
    exp_ps = (pos >= 0) && m_en && (pos < m_ws);
    exp_pt = (pos >= 0) && m_en && (pos < m_wt);
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    chk("frame_start", frame_start, exp_fs);
    chk("pwm_steer", pwm_steer, exp_ps);
    chk("pwm_throttle", pwm_throttle, exp_pt);
    chk("wdog_tripped", wdog_tripped, m_trip);
  end

  task automatic write_regs(input logic [31:0] c, input logic [31:0] s, input logic [31:0] t);
    repeat (20) @(negedge clock);
    reg_ctrl = c; reg_steer = s; reg_throttle = t; reg_wr_strobe = 1'b1;
    @(negedge clock);
    reg_wr_strobe = 1'b0;
  endtask

  // Wait (bounded) for a frame start, then count high cycles over one frame.
  task automatic measure(output int hs, output int ht);
    int n = 0;
    hs = 0; ht = 0;
    while (frame_start !== 1'b1 && n < 300) begin
      @(negedge clock); n++;
    end
    if (n >= 300) chk("frame_start_timeout", 32'd0, 32'd1);
    for (int i = 0; i < P; i++) begin
      hs += int'(pwm_steer); ht += int'(pwm_throttle);
      @(negedge clock);
    end
  endtask

  initial begin
    int hs, ht, n;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("first_frame_start", frame_start, 32'd1);
    measure(hs, ht);
    chk("reset_frame_steer", hs, 32'd0);
    chk("reset_frame_throttle", ht, 32'd0);
    chk("period_100", frame_start, 32'd1);

    write_regs(32'd1, 32'd8, 32'd15);
    measure(hs, ht);
    chk("steer_8", hs, 32'd8); chk("throttle_15", ht, 32'd15);
    write_regs(32'd1, 32'd2, 32'hFFFF_FFFF);
    measure(hs, ht);
    chk("steer_clamp_min", hs, 32'd5); chk("throttle_clamp_max", ht, 32'd20);
    write_regs(32'd3, 32'd8, 32'd15);
    measure(hs, ht);
    chk("force_neutral_s", hs, 32'd12); chk("force_neutral_t", ht, 32'd12);
    write_regs(32'd0, 32'd8, 32'd15);
    measure(hs, ht);
    chk("disabled_s", hs, 32'd0); chk("disabled_t", ht, 32'd0);
    write_regs(32'd1, 32'd8, 32'd15);
    measure(hs, ht);
    chk("reenable_s", hs, 32'd8); chk("reenable_t", ht, 32'd15);

    // Watchdog trip after three silent wraps.
    n = 0;
    while (wdog_tripped !== 1'b1 && n < 400) begin
      @(negedge clock); n++;
    end
    chk("wdog_trip_seen", wdog_tripped, 32'd1);
    chk("wdog_trip_at_frame_start", frame_start, 32'd1);
    measure(hs, ht);
    chk("tripped_s", hs, 32'd12); chk("tripped_t", ht, 32'd12);
    write_regs(32'd1, 32'd8, 32'd15);
    chk("trip_cleared", wdog_tripped, 32'd0);
    measure(hs, ht);
    chk("resume_s", hs, 32'd8); chk("resume_t", ht, 32'd15);

    // Strobe coincident with the wrap while two silent wraps have elapsed.
    repeat (P - 1) @(negedge clock);
    reg_wr_strobe = 1'b1;
    @(negedge clock);
    reg_wr_strobe = 1'b0;
    chk("coincident_frame_start", frame_start, 32'd1);
    chk("coincident_no_trip", wdog_tripped, 32'd0);
    repeat (250) @(negedge clock);
    chk("no_trip_later", wdog_tripped, 32'd0);

    // Reset in mid-frame at counter 50; strobe during reset is ignored.
    n = 0;
    while (frame_start !== 1'b1 && n < 300) begin
      @(negedge clock); n++;
    end
    repeat (50) @(negedge clock);
    reset = 1'b1; reg_wr_strobe = 1'b1;
    @(negedge clock);
    chk("rst_fs", frame_start, 32'd0); chk("rst_ps", pwm_steer, 32'd0);
    chk("rst_pt", pwm_throttle, 32'd0); chk("rst_trip", wdog_tripped, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0; reg_wr_strobe = 1'b0;
    @(negedge clock);
    chk("restart_frame_start", frame_start, 32'd1);
    chk("restart_pwm_low", pwm_steer, 32'd0);

    // Randomized phase: busy writes, then sparse writes so the watchdog trips.
    for (int i = 0; i < 3000; i++) begin
      reg_wr_strobe = (i < 1500) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 399) == 0);
      if (reg_wr_strobe) begin
        reg_ctrl     = $urandom;
        reg_steer    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 25));
        reg_throttle = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 25));
      end
      reset = ($urandom_range(0, 999) == 0);
      @(negedge clock);
    end
    reset = 1'b0; reg_wr_strobe = 1'b0;
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
